mul_div_unit: RTL and testbench

//  Iterative multi-cycle multiply/divide engine paired with the single-cycle ALU
//  in the EX stage. Runs MULT/MULTU/DIV/DIVU radix-2, one bit per clock.

---
 rtl/mul_div_if.sv | 32 +++
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Multiply/divide unit handshake and data bundle.
//   master : pipeline side (drives operands, op, start/abort, MTHI/MTLO)
//   slave  : mul_div_unit side (drives busy, done, hi, lo, div_zero)
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       sig_md_op;
  logic             sig_md_start;
  logic             sig_md_abort;
  logic             sig_hi_we;
  logic             sig_lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             sig_md_busy;
  logic             sig_md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             sig_div_zero;

  modport master (
    output src_a, src_b, sig_md_op, sig_md_start, sig_md_abort,
           sig_hi_we, sig_lo_we, wr_data,
    input  sig_md_busy, sig_md_done, hi, lo, sig_div_zero
  );

  modport slave (
    input  src_a, src_b, sig_md_op, sig_md_start, sig_md_abort,
           sig_hi_we, sig_lo_we, wr_data,
    output sig_md_busy, sig_md_done, hi, lo, sig_div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide engine holding architectural HI/LO.
// Ops: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
// Ports: clk, rst_n (async active-low), md (mul_div_if.slave: operands, op,
//   start/abort, MTHI/MTLO write, busy/done handshake, hi/lo, div_zero).
// Optional macro MULDIV_DIVZERO_EN: divide by zero finishes in one cycle and
//   raises sig_div_zero; otherwise it runs the normal algorithm, flag tied 0.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_div_if.slave   md
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
  logic             dz_pend_q, dz_pend_d;
  logic             dz_q, dz_d;
`endif

  // Operand magnitudes and signs (signed ops have op[0]==0)
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sa    = ~md.sig_md_op[0] & md.src_a[WIDTH-1];
  assign sb    = ~md.sig_md_op[0] & md.src_b[WIDTH-1];
  assign a_mag = sa ? WIDTH'(-md.src_a) : md.src_a;
  assign b_mag = sb ? WIDTH'(-md.src_b) : md.src_b;

  // Datapath step: p holds {acc, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  assign mul_sum  = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
  assign div_sh   = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = (div_sh >= {1'b0, b_q});

  // Sign correction applied in FIX
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  assign prod_fix = neg_lo_q ? PW'(-p_q) : p_q;
  assign fix_hi   = is_div_q ? (neg_hi_q ? WIDTH'(-p_q[PW-1:WIDTH]) : p_q[PW-1:WIDTH])
                             : prod_fix[PW-1:WIDTH];
  assign fix_lo   = is_div_q ? (neg_lo_q ? WIDTH'(-p_q[WIDTH-1:0]) : p_q[WIDTH-1:0])
                             : prod_fix[WIDTH-1:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      b_q       <= '0;
      p_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_pend_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_hi_q  <= neg_hi_d;
      neg_lo_q  <= neg_lo_d;
      b_q       <= b_d;
      p_q       <= p_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MULDIV_DIVZERO_EN
      dz_pend_q <= dz_pend_d;
      dz_q      <= dz_d;
`endif
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    b_d      = b_q;
    p_d      = p_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    dz_pend_d = dz_pend_q;
    dz_d      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (md.sig_hi_we) hi_d = md.wr_data;
        if (md.sig_lo_we) lo_d = md.wr_data;
        // abort on the same edge drops the request
        if (md.sig_md_start && !md.sig_md_abort) begin
          state_d  = S_RUN;
          cnt_d    = CW'(WIDTH - 1);
          is_div_d = md.sig_md_op[1];
          neg_lo_d = sa ^ sb;
          neg_hi_d = sa;
          if (md.sig_md_op[1]) begin
            p_d = {{WIDTH{1'b0}}, a_mag};
            b_d = b_mag;
          end else begin
            p_d = {{WIDTH{1'b0}}, b_mag};
            b_d = a_mag;
          end
`ifdef MULDIV_DIVZERO_EN
          dz_pend_d = 1'b0;
          // preload the final answer and skip straight to FIX
          if (md.sig_md_op[1] && (md.src_b == '0)) begin
            state_d   = S_FIX;
            dz_pend_d = 1'b1;
            p_d       = {md.src_a, {WIDTH{1'b1}}};
            neg_hi_d  = 1'b0;
            neg_lo_d  = 1'b0;
          end
`endif
        end
      end
      S_RUN: begin
        if (md.sig_md_abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            p_d = div_ge ? {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1}
                         : {div_sh[WIDTH-1:0],   p_q[WIDTH-2:0], 1'b0};
          end else begin
            p_d = {mul_sum, p_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!md.sig_md_abort) begin
          done_d = 1'b1;
          hi_d   = fix_hi;
          lo_d   = fix_lo;
`ifdef MULDIV_DIVZERO_EN
          dz_d   = dz_pend_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign md.sig_md_busy = busy_q;
  assign md.sig_md_done = done_q;
  assign md.hi          = hi_q;
  assign md.lo          = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign md.sig_div_zero = dz_q;
`else
  assign md.sig_div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): vector table, randomized
// ops against an arithmetic reference model, and hand-written corner sequences.
module tb_mul_div_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mul_div_if #(.WIDTH(W)) m ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

`ifdef MULDIV_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: begin pr = 64'(sa * sb); return pr; end
      2'b01: begin pr = ua * ub; return pr; end
      2'b10: begin
        if (b == 32'h0) return {a, (DZ_EN || !a[31]) ? 32'hFFFF_FFFF : 32'h1};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (DZ_EN && op[1] && (b == 32'h0)) return 1;
    return W + 1;
  endfunction

  function automatic logic exp_dz(input logic [1:0] op, input logic [31:0] b);
    return DZ_EN && op[1] && (b == 32'h0);
  endfunction

  // Issue one op and wait for done; lat = edges after E0 until done seen
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output int bcnt, output logic dzf);
    @(negedge clk);
    m.src_a = a; m.src_b = b; m.sig_md_op = op; m.sig_md_start = 1'b1;
    @(posedge clk); #1;
    m.sig_md_start = 1'b0;
    lat = 0;
    bcnt = m.sig_md_busy ? 1 : 0;
    while (!m.sig_md_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (m.sig_md_busy) bcnt++;
    end
    rh = m.hi; rl = m.lo; dzf = m.sig_div_zero;
    @(posedge clk); #1;
    check("done_pulse_width", 64'(m.sig_md_done), 64'(0));
  endtask

  // Count done pulses over n cycles
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (m.sig_md_done) cnt++;
    end
  endtask

  initial begin
    logic [31:0] rh, rl, a, b;
    logic [1:0]  op;
    logic [63:0] e;
    logic        dzf;
    int          lat, bcnt, dc;
    n_tests = 0;
    n_fail  = 0;
    m.src_a = '0; m.src_b = '0; m.sig_md_op = '0; m.sig_md_start = 1'b0;
    m.sig_md_abort = 1'b0; m.sig_hi_we = 1'b0; m.sig_lo_we = 1'b0; m.wr_data = '0;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFA};
    vecs[3] = '{2'b11, 32'h0000_0014, 32'h0000_0003, 32'h0000_0002, 32'h0000_0006};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[6] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(m.hi), 64'(0));
    check("reset_lo", 64'(m.lo), 64'(0));
    check("reset_busy_done_dz", 64'({m.sig_md_busy, m.sig_md_done, m.sig_div_zero}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI/MTLO then aborted MULT: hi/lo untouched, no done
    @(negedge clk);
    m.wr_data = 32'h1234; m.sig_hi_we = 1'b1;
    @(negedge clk);
    m.wr_data = 32'h0; m.sig_hi_we = 1'b0; m.sig_lo_we = 1'b1;
    @(negedge clk);
    m.sig_lo_we = 1'b0;
    m.src_a = 32'd2; m.src_b = 32'd3; m.sig_md_op = 2'b00; m.sig_md_start = 1'b1;
    @(posedge clk); #1;
    m.sig_md_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    m.sig_md_abort = 1'b1;
    @(posedge clk); #1;
    m.sig_md_abort = 1'b0;
    check("abort_busy", 64'(m.sig_md_busy), 64'(0));
    count_done(40, dc);
    check("abort_no_done", 64'(dc), 64'(0));
    check("abort_hi", 64'(m.hi), 64'h1234);
    check("abort_lo", 64'(m.lo), 64'h0);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat, bcnt, dzf);
      check($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      check($sformatf("vec%0d_dz", i), 64'(dzf), 64'(exp_dz(vecs[i].op, vecs[i].b)));
    end

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      e = model(op, a, b);
      run_op(op, a, b, rh, rl, lat, bcnt, dzf);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), {rh, rl}, e);
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(op, b)));
    end

    // start while busy: ignored, single done with first result
    @(negedge clk);
    m.src_a = 32'd100; m.src_b = 32'd7; m.sig_md_op = 2'b11; m.sig_md_start = 1'b1;
    @(negedge clk);
    m.sig_md_start = 1'b0;
    repeat (5) @(negedge clk);
    m.src_a = 32'd3; m.src_b = 32'd3; m.sig_md_op = 2'b01; m.sig_md_start = 1'b1;
    @(negedge clk);
    m.sig_md_start = 1'b0;
    count_done(60, dc);
    check("busy_start_single_done", 64'(dc), 64'(1));
    check("busy_start_result", {m.hi, m.lo}, {32'd2, 32'd14});

    // Back-to-back: second start in the done cycle
    @(negedge clk);
    m.src_a = 32'd6; m.src_b = 32'd7; m.sig_md_op = 2'b01; m.sig_md_start = 1'b1;
    @(posedge clk); #1;
    m.sig_md_start = 1'b0;
    lat = 0;
    while (!m.sig_md_done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("b2b_first", {m.hi, m.lo}, {32'd0, 32'd42});
    @(negedge clk);
    m.src_a = 32'hFFFF_FFF0; m.src_b = 32'd4; m.sig_md_op = 2'b10; m.sig_md_start = 1'b1;
    @(posedge clk); #1;
    m.sig_md_start = 1'b0;
    check("b2b_busy", 64'({m.sig_md_busy, m.sig_md_done}), 64'(2'b10));
    lat = 0;
    while (!m.sig_md_done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("b2b_lat", 64'(lat), 64'(W + 1));
    check("b2b_second", {m.hi, m.lo}, {32'd0, 32'hFFFF_FFFC});

    // start with MTHI on same edge: write lands now, result overwrites later
    @(negedge clk);
    m.src_a = 32'd4; m.src_b = 32'd5; m.sig_md_op = 2'b01; m.sig_md_start = 1'b1;
    m.wr_data = 32'hABCD; m.sig_hi_we = 1'b1;
    @(posedge clk); #1;
    m.sig_md_start = 1'b0; m.sig_hi_we = 1'b0;
    check("start_we_hi_now", 64'(m.hi), 64'hABCD);
    lat = 0;
    while (!m.sig_md_done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("start_we_result", {m.hi, m.lo}, {32'd0, 32'd20});

    // MTHI while busy is ignored
    @(negedge clk);
    m.src_a = 32'd9; m.src_b = 32'd9; m.sig_md_op = 2'b01; m.sig_md_start = 1'b1;
    @(negedge clk);
    m.sig_md_start = 1'b0; m.sig_hi_we = 1'b1; m.wr_data = 32'h5555;
    @(negedge clk);
    m.sig_hi_we = 1'b0;
    #1;
    check("we_busy_ignored", 64'(m.hi), 64'd0);
    count_done(40, dc);
    check("we_busy_result", {m.hi, m.lo}, {32'd0, 32'd81});

    // abort and start on the same IDLE edge: start dropped
    @(negedge clk);
    m.src_a = 32'd1; m.src_b = 32'd1; m.sig_md_op = 2'b01;
    m.sig_md_start = 1'b1; m.sig_md_abort = 1'b1;
    @(posedge clk); #1;
    m.sig_md_start = 1'b0; m.sig_md_abort = 1'b0;
    check("abort_start_busy", 64'(m.sig_md_busy), 64'(0));
    count_done(40, dc);
    check("abort_start_no_done", 64'(dc), 64'(0));

    // Async reset mid-operation
    @(negedge clk);
    m.src_a = 32'd123; m.src_b = 32'd456; m.sig_md_op = 2'b01; m.sig_md_start = 1'b1;
    @(negedge clk);
    m.sig_md_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", {m.hi, m.lo, 30'h0, m.sig_md_busy, m.sig_md_done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, dc);
    check("midrst_no_done", 64'(dc), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
